// File: rtl/perf_counter_ctrl.sv
// -----------------------------------------------------------------------------
// perf_counter_ctrl
//
// MMIO-mapped performance counter controller. It owns a free-running cycle
// counter and a retired-instruction counter. Software moves it between
// IDLE / ARMED / RUN through the CTRL register. When a non-zero LIMIT is
// programmed, it stops by itself once the cycle count's low word reaches
// LIMIT.
//
// Register map (word index on addr):
//   0  CTRL (write) / STATUS (read: {done, state[1:0]})
//   1  CYCLE_LO   read also snapshots CYCLE_HI into the cycle shadow
//   2  CYCLE_HI   returns the cycle shadow
//   3  INSTR_LO   read also snapshots INSTR_HI into the instr shadow
//   4  INSTR_HI   returns the instr shadow
//   5  LIMIT      read/write, 0 disables auto-stop
//   6-7          unmapped: read 0, writes ignored
//
// Ports:
//   clk          core clock, rising edge
//   rst_n        synchronous active-low reset
//   wr_en        MMIO write strobe
//   rd_en        MMIO read strobe
//   addr         register word index
//   wdata        write data
//   inst_retire  one pulse per retired instruction
//   rdata        registered read data (valid with rd_valid)
//   rd_valid     one-cycle pulse the cycle after an accepted rd_en
//   done         sticky flag, set on limit auto-stop
//   running      high while the state is RUN
//
// CNT_W must equal 2*XLEN: each counter is read as exactly two bus words.
// -----------------------------------------------------------------------------
module perf_counter_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic            rd_en,
  input  logic [2:0]      addr,
  input  logic [XLEN-1:0] wdata,
  input  logic            inst_retire,
  output logic [XLEN-1:0] rdata,
  output logic            rd_valid,
  output logic            done,
  output logic            running
);

  // STATUS read encoding is fixed by software: IDLE=0, ARMED=1, RUN=2.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_CYC_LO = 3'd1;
  localparam logic [2:0] A_CYC_HI = 3'd2;
  localparam logic [2:0] A_INS_LO = 3'd3;
  localparam logic [2:0] A_INS_HI = 3'd4;
  localparam logic [2:0] A_LIMIT  = 3'd5;

  // CTRL bit positions.
  localparam int B_START = 0;
  localparam int B_STOP  = 1;
  localparam int B_CLEAR = 2;
  localparam int B_ARM   = 3;

  // ---------------------------------------------------------------------------
  // Architectural state
  // ---------------------------------------------------------------------------
  state_e            state;
  state_e            state_nx;
  logic              done_nx;
  logic [CNT_W-1:0]  cyc_cnt;
  logic [CNT_W-1:0]  ins_cnt;
  logic [XLEN-1:0]   cyc_shadow;
  logic [XLEN-1:0]   ins_shadow;
  logic [XLEN-1:0]   limit;

  // ---------------------------------------------------------------------------
  // Command decode
  // ---------------------------------------------------------------------------
  logic ctrl_wr;
  logic cmd_start;
  logic cmd_stop;
  logic cmd_clear;
  logic cmd_arm;
  logic cmd_any;

  assign ctrl_wr   = wr_en && (addr == A_CTRL);
  assign cmd_start = ctrl_wr && wdata[B_START];
  assign cmd_stop  = ctrl_wr && wdata[B_STOP];
  assign cmd_clear = ctrl_wr && wdata[B_CLEAR];
  assign cmd_arm   = ctrl_wr && wdata[B_ARM];
  // A CTRL write carrying no command bits is a no-op, so it does not count
  // as a command (in particular it does not mask the limit auto-stop).
  assign cmd_any   = cmd_start || cmd_stop || cmd_clear || cmd_arm;

  // ---------------------------------------------------------------------------
  // Counting
  // ---------------------------------------------------------------------------
  logic             in_run;
  logic             arm_fire;
  logic             cyc_inc;
  logic             ins_inc;
  logic [CNT_W-1:0] cyc_plus1;
  logic [CNT_W-1:0] ins_plus1;
  logic             limit_hit;

  assign in_run    = (state == ST_RUN);
  // The first retire seen while ARMED both starts the run and is counted.
  assign arm_fire  = (state == ST_ARMED) && inst_retire;
  assign cyc_inc   = in_run || arm_fire;
  assign ins_inc   = (in_run && inst_retire) || arm_fire;
  assign cyc_plus1 = cyc_cnt + CNT_W'(1);
  assign ins_plus1 = ins_cnt + CNT_W'(1);

  // Auto-stop compares the post-increment value so the counter stops showing
  // exactly LIMIT. Any software command on the same edge takes precedence.
  assign limit_hit = in_run && (limit != '0) &&
                     (cyc_plus1[XLEN-1:0] == limit) && !cmd_any;

  // ---------------------------------------------------------------------------
  // Next state and sticky done
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_nx = state;
    done_nx  = done;

    if (arm_fire) begin
      state_nx = ST_RUN;
    end
    if (limit_hit) begin
      state_nx = ST_IDLE;
      done_nx  = 1'b1;
    end

    if (cmd_clear) begin
      done_nx = 1'b0;
    end

    // STOP > START > ARM. CLEAR alone leaves the state transition untouched.
    if (cmd_stop) begin
      state_nx = ST_IDLE;
    end else if (cmd_start) begin
      state_nx = ST_RUN;
      done_nx  = 1'b0;
    end else if (cmd_arm) begin
      state_nx = ST_ARMED;
      done_nx  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux: samples registers as they are before this edge's updates.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] rd_word;

  always_comb begin
    rd_word = '0;
    unique case (addr)
      A_CTRL:   rd_word = {{(XLEN-3){1'b0}}, done, state};
      A_CYC_LO: rd_word = cyc_cnt[XLEN-1:0];
      A_CYC_HI: rd_word = cyc_shadow;
      A_INS_LO: rd_word = ins_cnt[XLEN-1:0];
      A_INS_HI: rd_word = ins_shadow;
      A_LIMIT:  rd_word = limit;
      default:  rd_word = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments throughout, so every register in this
      // block sees the pre-edge value of every other one.
      state      <= ST_IDLE;
      running    <= 1'b0;
      done       <= 1'b0;
      cyc_cnt    <= '0;
      ins_cnt    <= '0;
      cyc_shadow <= '0;
      ins_shadow <= '0;
      limit      <= '0;
      rdata      <= '0;
      rd_valid   <= 1'b0;
    end else begin
      state    <= state_nx;
      running  <= (state_nx == ST_RUN);
      done     <= done_nx;
      rd_valid <= rd_en;

      if (rd_en) begin
        rdata <= rd_word;
      end

      if (wr_en && (addr == A_LIMIT)) begin
        limit <= wdata;
      end

      // CLEAR discards any increment on the same edge. A shadow snapshot can
      // never coincide with CLEAR because both share the single addr field.
      if (cmd_clear) begin
        cyc_cnt    <= '0;
        ins_cnt    <= '0;
        cyc_shadow <= '0;
        ins_shadow <= '0;
      end else begin
        if (cyc_inc) begin
          cyc_cnt <= cyc_plus1;
        end
        if (ins_inc) begin
          ins_cnt <= ins_plus1;
        end
        // Snapshot the high word when the low word is read, so a LO-then-HI
        // read pair sees a consistent 64-bit value even while counting.
        if (rd_en && (addr == A_CYC_LO)) begin
          cyc_shadow <= cyc_cnt[CNT_W-1:XLEN];
        end
        if (rd_en && (addr == A_INS_LO)) begin
          ins_shadow <= ins_cnt[CNT_W-1:XLEN];
        end
      end
    end
  end

endmodule

// File: tb/tb_perf_counter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_perf_counter_ctrl
//
// Directed scenarios followed by randomized traffic. A behavioural model of the
// register map is stepped on every rising edge, and all DUT outputs are
// compared against it 1 ns after the edge.
// -----------------------------------------------------------------------------
module tb_perf_counter_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic [31:0] wdata = 32'd0;
  logic        inst_retire = 1'b0;
  logic [31:0] rdata;
  logic        rd_valid;
  logic        done;
  logic        running;

  int n_checks = 0;
  int n_errors = 0;

  perf_counter_ctrl #(.XLEN(32), .CNT_W(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .addr        (addr),
    .wdata       (wdata),
    .inst_retire (inst_retire),
    .rdata       (rdata),
    .rd_valid    (rd_valid),
    .done        (done),
    .running     (running)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: 0 = idle, 1 = armed, 2 = run
  // ---------------------------------------------------------------------------
  int          m_state = 0;
  bit [63:0]   m_cyc = '0;
  bit [63:0]   m_ins = '0;
  bit [31:0]   m_cyc_hi_snap = '0;
  bit [31:0]   m_ins_hi_snap = '0;
  bit [31:0]   m_limit = '0;
  bit          m_done = 1'b0;
  bit [31:0]   m_rdata = '0;
  bit          m_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return 32'(m_done) * 4 + 32'(m_state);
      3'd1:    return m_cyc[31:0];
      3'd2:    return m_cyc_hi_snap;
      3'd3:    return m_ins[31:0];
      3'd4:    return m_ins_hi_snap;
      3'd5:    return m_limit;
      default: return 32'd0;
    endcase
  endfunction

  // Apply one clock edge's worth of the register-map rules to the model.
  task automatic model_step();
    int        n_state;
    bit [63:0] n_cyc;
    bit [63:0] n_ins;
    bit        n_done;
    bit        cmd;
    if (!rst_n) begin
      m_state = 0; m_cyc = '0; m_ins = '0; m_cyc_hi_snap = '0; m_ins_hi_snap = '0;
      m_limit = '0; m_done = 1'b0; m_rdata = '0; m_valid = 1'b0;
      return;
    end
    n_state = m_state;
    n_cyc   = m_cyc;
    n_ins   = m_ins;
    n_done  = m_done;
    cmd     = wr_en && (addr == 3'd0) && (wdata[3:0] != 4'd0);

    // Reads see the registers as they were before this edge.
    m_valid = rd_en;
    if (rd_en) begin
      m_rdata = model_read(addr);
      if (addr == 3'd1) m_cyc_hi_snap = m_cyc[63:32];
      if (addr == 3'd3) m_ins_hi_snap = m_ins[63:32];
    end

    if (m_state == 2) begin
      n_cyc = m_cyc + 1;
      if (inst_retire) n_ins = m_ins + 1;
      if (!cmd && m_limit != 0 && n_cyc[31:0] == m_limit) begin
        n_state = 0;
        n_done  = 1'b1;
      end
    end else if (m_state == 1 && inst_retire) begin
      n_state = 2;
      n_cyc   = m_cyc + 1;
      n_ins   = m_ins + 1;
    end

    if (wr_en && addr == 3'd5) m_limit = wdata;

    if (cmd) begin
      if (wdata[2]) begin
        n_cyc = '0; n_ins = '0; m_cyc_hi_snap = '0; m_ins_hi_snap = '0; n_done = 1'b0;
      end
      if (wdata[1]) n_state = 0;
      else if (wdata[0]) begin n_state = 2; n_done = 1'b0; end
      else if (wdata[3]) begin n_state = 1; n_done = 1'b0; end
    end

    m_state = n_state;
    m_cyc   = n_cyc;
    m_ins   = n_ins;
    m_done  = n_done;
  endtask

  // One clock: step the model on the edge, compare outputs 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("running",  32'(running),  32'(m_state == 2));
    check("done",     32'(done),     32'(m_done));
    check("rd_valid", 32'(rd_valid), 32'(m_valid));
    check("rdata",    rdata,         m_rdata);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    wr_en = 1'b1; addr = a; wdata = d;
    tick();
    wr_en = 1'b0; wdata = 32'd0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    rd_en = 1'b1; addr = a;
    tick();
    rd_en = 1'b0;
    v = rdata;
  endtask

  logic [31:0] v;

  initial begin
    // ---- Reset and start ----------------------------------------------------
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_rdata",    rdata,            32'd0);
    check("rst_rd_valid", 32'(rd_valid),    32'd0);
    check("rst_running",  32'(running),     32'd0);
    check("rst_done",     32'(done),        32'd0);
    rst_n = 1'b1;
    wr(3'd0, 32'h1);
    check("start_running", 32'(running), 32'd1);
    repeat (10) tick();
    rd(3'd1, v); check("start_cyc_lo", v, 32'd10);
    rd(3'd2, v); check("start_cyc_hi", v, 32'd0);
    rd(3'd0, v); check("start_status", v, 32'h2);

    // ---- Arm and limit ------------------------------------------------------
    wr(3'd0, 32'h6);                      // STOP + CLEAR
    wr(3'd5, 32'd20);
    wr(3'd0, 32'h8);                      // ARM
    rd(3'd0, v); check("armed_status", v, 32'h1);
    repeat (4) tick();
    check("armed_not_running", 32'(running), 32'd0);
    for (int i = 0; i < 40; i++) begin
      inst_retire = (i % 2 == 0);
      tick();
      if (i == 0) check("arm_fire_running", 32'(running), 32'd1);
    end
    inst_retire = 1'b0;
    check("limit_done", 32'(done), 32'd1);
    rd(3'd3, v); check("limit_instr", v, 32'd10);
    rd(3'd1, v); check("limit_cycle", v, 32'd20);
    rd(3'd0, v); check("limit_status", v, 32'h4);

    // ---- Wrap and atomic high word -----------------------------------------
    wr(3'd0, 32'h4);                      // CLEAR
    wr(3'd5, 32'd0);
    force dut.cyc_cnt = 64'h0000_0000_FFFF_FFFF;
    #2;
    release dut.cyc_cnt;
    m_cyc = 64'h0000_0000_FFFF_FFFF;
    wr(3'd0, 32'h1);                      // START
    tick();                               // one RUN edge: carry into high word
    rd(3'd1, v); check("wrap_lo", v, 32'd0);
    repeat (3) tick();
    rd(3'd2, v); check("wrap_hi", v, 32'd1);

    // ---- Command priority ---------------------------------------------------
    repeat (5) tick();
    wr(3'd0, 32'h7);                      // START+STOP+CLEAR
    check("prio_running", 32'(running), 32'd0);
    repeat (3) tick();
    rd(3'd1, v); check("prio_cyc", v, 32'd0);
    rd(3'd3, v); check("prio_ins", v, 32'd0);
    rd(3'd0, v); check("prio_status", v, 32'd0);

    // ---- Clear plus count ---------------------------------------------------
    inst_retire = 1'b1;
    wr(3'd0, 32'h5);                      // START+CLEAR with a retire
    wr(3'd0, 32'h2);                      // one more counting edge, then STOP
    inst_retire = 1'b0;
    rd(3'd1, v); check("clrcnt_cyc", v, 32'd1);
    rd(3'd3, v); check("clrcnt_ins", v, 32'd1);

    // ---- Mid-run reset ------------------------------------------------------
    wr(3'd5, 32'd5);
    wr(3'd0, 32'h1);
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    check("midrst_running", 32'(running), 32'd0);
    check("midrst_rdata",   rdata,        32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("midrst_no_done", 32'(done), 32'd0);
    end
    rd(3'd1, v); check("midrst_cyc", v, 32'd0);
    rd(3'd5, v); check("midrst_limit", v, 32'd0);

    // ---- Randomized traffic -------------------------------------------------
    for (int i = 0; i < 4000; i++) begin
      rst_n       = ($urandom_range(0, 599) != 0);
      inst_retire = 1'($urandom_range(0, 1));
      rd_en       = ($urandom_range(0, 2) != 0);
      wr_en       = ($urandom_range(0, 5) == 0);
      addr        = 3'($urandom_range(0, 7));
      if (addr == 3'd0)
        wdata = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 15));
      else if (addr == 3'd5)
        wdata = 32'($urandom_range(0, 40));
      else
        wdata = 32'($urandom);
      tick();
    end
    rst_n = 1'b1; rd_en = 1'b0; wr_en = 1'b0; inst_retire = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
